// File: rtl/sd_dat_rx_deserializer_pkg.sv
// Shared definitions for the SD DAT0 receive path and its CRC16 engine.
//   state_t      : receive FSM states
//   CRC16_POLY   : CCITT polynomial x^16+x^12+x^5+1
//   CRC16_INIT   : CRC register reset/clear value
//   START_BIT / END_BIT : line levels framing a data block
package sd_dat_rx_deserializer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    DATA,
    CRC,
    END,
    DONE
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'h0000;

  localparam logic START_BIT = 1'b0;
  localparam logic END_BIT   = 1'b1;

endpackage

// File: rtl/sd_dat_rx_deserializer_if.sv
// Host/FIFO-side bundle of the DAT0 receive stage.
//   enable, dat_in, timeout_reg, fifo_full     : into the receiver
//   data_out, write_fifo                       : FIFO push
//   busy, block_done, *_error, overflow        : status to the controller
// slave = receiver side, master = controller/FIFO side.
interface sd_dat_rx_deserializer_if;
  logic        enable;
  logic        dat_in;
  logic [15:0] timeout_reg;
  logic        fifo_full;
  logic [31:0] data_out;
  logic        write_fifo;
  logic        busy;
  logic        block_done;
  logic        crc_error;
  logic        end_error;
  logic        timeout_error;
  logic        overflow;

  modport slave (
    input  enable, dat_in, timeout_reg, fifo_full,
    output data_out, write_fifo, busy, block_done,
           crc_error, end_error, timeout_error, overflow
  );

  modport master (
    output enable, dat_in, timeout_reg, fifo_full,
    input  data_out, write_fifo, busy, block_done,
           crc_error, end_error, timeout_error, overflow
  );
endinterface

// File: rtl/sd_crc16_serial.sv
// Bit-serial CRC16-CCITT, MSB-first. Shared by the DAT receive and transmit paths.
//   sd_clock, reset : clock, async active-high reset
//   clear           : synchronous reload to the init value
//   bit_valid       : advance the CRC with bit_in this cycle
//   crc             : current CRC register
module sd_crc16_serial
  import sd_dat_rx_deserializer_pkg::*;
(
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        bit_valid,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic feedback;
  assign feedback = crc[15] ^ bit_in;

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      crc <= CRC16_INIT;
    end else if (clear) begin
      crc <= CRC16_INIT;
    end else if (bit_valid) begin
      crc <= {crc[14:0], 1'b0} ^ (feedback ? CRC16_POLY : '0);
    end
  end

endmodule

// File: rtl/sd_dat_rx_deserializer.sv
// SD DAT0 receive deserializer: waits for a start bit, packs one block
// MSB-first into 32-bit FIFO words, then checks CRC16 and end bit.
//   sd_clock, reset : SD bit clock, async active-high reset
//   bus (slave)     : enable/dat_in/timeout_reg/fifo_full in;
//                     data_out/write_fifo push and status flags out
module sd_dat_rx_deserializer
  import sd_dat_rx_deserializer_pkg::*;
#(
  parameter int BLOCK_BYTES = 512,
  parameter int CNT_W       = 16
) (
  input  logic                     sd_clock,
  input  logic                     reset,
  sd_dat_rx_deserializer_if.slave  bus
);

  localparam int TOTAL_BITS = BLOCK_BYTES * 8;
  localparam int BIT_W      = $clog2(TOTAL_BITS);

  state_t            state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_nxt;
  logic [30:0]       shift;
  logic [15:0]       rx_crc;
  logic [15:0]       crc;
  logic              crc_clear;
  logic              crc_valid;

  assign crc_clear = (state == IDLE) && bus.enable;
  assign crc_valid = (state == DATA);
  assign wait_nxt  = wait_cnt + 1'b1;

  sd_crc16_serial u_crc (
    .sd_clock  (sd_clock),
    .reset     (reset),
    .clear     (crc_clear),
    .bit_valid (crc_valid),
    .bit_in    (bus.dat_in),
    .crc       (crc)
  );

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      bit_cnt           <= '0;
      wait_cnt          <= '0;
      shift             <= '0;
      rx_crc            <= '0;
      bus.data_out      <= '0;
      bus.write_fifo    <= 1'b0;
      bus.busy          <= 1'b0;
      bus.block_done    <= 1'b0;
      bus.crc_error     <= 1'b0;
      bus.end_error     <= 1'b0;
      bus.timeout_error <= 1'b0;
      bus.overflow      <= 1'b0;
    end else begin
      bus.write_fifo <= 1'b0;
      bus.block_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            state             <= WAIT_START;
            bus.busy          <= 1'b1;
            bit_cnt           <= '0;
            wait_cnt          <= '0;
            rx_crc            <= '0;
            bus.crc_error     <= 1'b0;
            bus.end_error     <= 1'b0;
            bus.timeout_error <= 1'b0;
            bus.overflow      <= 1'b0;
          end
        end
        WAIT_START: begin
          // Start bit takes priority over a coincident timeout.
          if (bus.dat_in == START_BIT) begin
            state   <= DATA;
            bit_cnt <= '0;
          end else begin
            wait_cnt <= wait_nxt;
            if ((bus.timeout_reg != '0) && (16'(wait_nxt) == bus.timeout_reg)) begin
              bus.timeout_error <= 1'b1;
              bus.block_done    <= 1'b1;
              bus.busy          <= 1'b0;
              state             <= IDLE;
            end
          end
        end
        DATA: begin
          shift <= {shift[29:0], bus.dat_in};
          // Completed word is copied into data_out so shifting never stalls.
          if (bit_cnt[4:0] == 5'd31) begin
            if (bus.fifo_full) begin
              bus.overflow <= 1'b1;
            end else begin
              bus.data_out   <= {shift, bus.dat_in};
              bus.write_fifo <= 1'b1;
            end
          end
          if (bit_cnt == BIT_W'(TOTAL_BITS - 1)) begin
            bit_cnt <= '0;
            state   <= CRC;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        CRC: begin
          rx_crc <= {rx_crc[14:0], bus.dat_in};
          if (bit_cnt == BIT_W'(15)) begin
            bit_cnt <= '0;
            state   <= END;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        END: begin
          if (bus.dat_in != END_BIT) bus.end_error <= 1'b1;
          if (rx_crc != crc)         bus.crc_error <= 1'b1;
          bus.block_done <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_dat_rx_deserializer.sv
module tb_sd_dat_rx_deserializer;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  int          wr_cyc[$];
  logic [31:0] wr_dat[$];
  int          done_cyc[$];

  sd_dat_rx_deserializer_if bus();

  sd_dat_rx_deserializer #(.BLOCK_BYTES(8), .CNT_W(16)) dut (
    .sd_clock (clk),
    .reset    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.write_fifo) begin
      wr_cyc.push_back(cyc);
      wr_dat.push_back(bus.data_out);
    end
    if (bus.block_done) done_cyc.push_back(cyc);
  end

  typedef struct {
    logic [63:0] data;
    bit          flip_crc;
    bit          end_bit;
    bit          full_first;
    bit          exp_crc_err;
    bit          exp_end_err;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [15:0] crc16_of(input logic [63:0] d);
    logic [15:0] c;
    c = 16'h0000;
    for (int i = 63; i >= 0; i--) begin
      c = (c[15] ^ d[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    wr_cyc.delete();
    wr_dat.delete();
    done_cyc.delete();
  endtask

  task automatic send_block(input vec_t v, output int s);
    logic [15:0] c;
    c = crc16_of(v.data);
    if (v.flip_crc) c[3] = ~c[3];
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    bus.dat_in = 1'b1;
    repeat (10) tick();
    bus.dat_in = 1'b0;
    s = cyc;
    tick();
    for (int i = 0; i < 64; i++) begin
      bus.dat_in    = v.data[63-i];
      bus.fifo_full = v.full_first && (i == 31);
      tick();
    end
    bus.fifo_full = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.dat_in = c[15-i];
      tick();
    end
    bus.dat_in = v.end_bit;
    tick();
    bus.dat_in = 1'b1;
    repeat (4) tick();
  endtask

  task automatic check_block(input string tag, input vec_t v, input int s);
    if (v.exp_ovf) begin
      chk({tag, "_nwr"}, wr_cyc.size(), 1);
      if (wr_cyc.size() == 1) begin
        chk({tag, "_w1cyc"}, wr_cyc[0], s + 65);
        chk({tag, "_w1dat"}, wr_dat[0], v.data[31:0]);
      end
    end else begin
      chk({tag, "_nwr"}, wr_cyc.size(), 2);
      if (wr_cyc.size() == 2) begin
        chk({tag, "_w0cyc"}, wr_cyc[0], s + 33);
        chk({tag, "_w0dat"}, wr_dat[0], v.data[63:32]);
        chk({tag, "_w1cyc"}, wr_cyc[1], s + 65);
        chk({tag, "_w1dat"}, wr_dat[1], v.data[31:0]);
      end
    end
    chk({tag, "_ndone"}, done_cyc.size(), 1);
    if (done_cyc.size() == 1) chk({tag, "_donecyc"}, done_cyc[0], s + 82);
    chk({tag, "_crc_err"}, bus.crc_error, v.exp_crc_err);
    chk({tag, "_end_err"}, bus.end_error, v.exp_end_err);
    chk({tag, "_ovf"}, bus.overflow, v.exp_ovf);
    chk({tag, "_tmo"}, bus.timeout_error, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    int s;
    int e0;
    checks = 0;
    errors = 0;
    cyc    = 0;

    vecs[0] = '{64'hDEADBEEF01234567, 0, 1, 0, 0, 0, 0};
    vecs[1] = '{64'hDEADBEEF01234567, 1, 1, 0, 1, 0, 0};
    vecs[2] = '{64'hDEADBEEF01234567, 0, 0, 0, 0, 1, 0};
    vecs[3] = '{64'hDEADBEEF01234567, 0, 1, 1, 0, 0, 1};
    vecs[4] = '{64'hFFFFFFFF00000000, 0, 1, 0, 0, 0, 0};

    rst             = 1'b1;
    bus.enable      = 1'b0;
    bus.dat_in      = 1'b1;
    bus.timeout_reg = 16'd100;
    bus.fifo_full   = 1'b0;
    repeat (3) tick();
    chk("rst_data_out", bus.data_out, 32'h0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_flags", {bus.write_fifo, bus.block_done, bus.crc_error,
                      bus.end_error, bus.timeout_error, bus.overflow}, 6'b0);
    rst = 1'b0;
    repeat (2) tick();

    for (int k = 0; k < 5; k++) begin
      clear_logs();
      send_block(vecs[k], s);
      check_block($sformatf("vec%0d", k), vecs[k], s);
    end

    // Timeout after 100 cycles in WAIT_START.
    clear_logs();
    bus.timeout_reg = 16'd100;
    bus.dat_in      = 1'b1;
    bus.enable      = 1'b1;
    tick();
    bus.enable = 1'b0;
    e0 = cyc;
    repeat (110) tick();
    chk("tmo_ndone", done_cyc.size(), 1);
    if (done_cyc.size() == 1) chk("tmo_donecyc", done_cyc[0], e0 + 100);
    chk("tmo_flag", bus.timeout_error, 1'b1);
    chk("tmo_nwr", wr_cyc.size(), 0);
    chk("tmo_busy", bus.busy, 1'b0);

    // timeout_reg = 0 never expires; enable while busy is ignored.
    clear_logs();
    bus.timeout_reg = 16'd0;
    bus.enable      = 1'b1;
    tick();
    bus.enable = 1'b0;
    chk("notmo_cleared", bus.timeout_error, 1'b0);
    repeat (500) tick();
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    repeat (500) tick();
    chk("notmo_busy", bus.busy, 1'b1);
    chk("notmo_ndone", done_cyc.size(), 0);
    chk("notmo_flag", bus.timeout_error, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.timeout_reg = 16'd100;

    // Reset 20 bits into DATA, after a good block left data_out nonzero.
    clear_logs();
    send_block(vecs[0], s);
    clear_logs();
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    repeat (5) tick();
    bus.dat_in = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      bus.dat_in = ~bus.dat_in;
      tick();
    end
    rst = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_data_out", bus.data_out, 32'h0);
    chk("midrst_flags", {bus.write_fifo, bus.block_done, bus.crc_error,
                         bus.end_error, bus.timeout_error, bus.overflow}, 6'b0);
    bus.dat_in = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("midrst_nwr", wr_cyc.size(), 0);
    clear_logs();
    send_block(vecs[0], s);
    check_block("postrst", vecs[0], s);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_dat_rx_deserializer.md
Name: sd_dat_rx_deserializer

Overview:
- Card-to-host receive stage for the SD DAT0 line, sitting between the DAT pad and the receive FIFO, alongside the dat_phys transmit path.
- Waits for a start bit, shifts in one block of data MSB-first and packs it into 32-bit words pushed to the FIFO.
- Checks the trailing CRC16 and end bit, then reports status to the host-side controller.
- Clocked by sd_clock, the same clock that drives the pad.

Parameters:
BLOCK_BYTES, 512, data bytes per block; must be a multiple of 4 and at least 4.
CNT_W, 16, width of the wait-for-start-bit timeout counter.

Ports:
sd_clock  input  1  SD bit clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high; clears all state.
enable  input  1  arms reception of one block; sampled only in IDLE.
dat_in  input  1  serial DAT0 line from the pad; idles high.
timeout_reg  input  16  cycles to wait for the start bit; 0 disables the timeout.
fifo_full  input  1  receive FIFO full flag.
data_out  output  32  assembled word; valid while write_fifo is high.
write_fifo  output  1  one-cycle FIFO push strobe.
busy  output  1  high in any state other than IDLE.
block_done  output  1  one-cycle pulse when a block terminates, with or without error.
crc_error  output  1  sticky: received CRC differs from computed CRC.
end_error  output  1  sticky: end bit sampled as 0.
timeout_error  output  1  sticky: no start bit within timeout_reg cycles.
overflow  output  1  sticky: a word completed while fifo_full was high.

Behaviour:
- Reset values: all outputs 0, data_out = 0, state IDLE, CRC register 0, counters 0.
- IDLE:
  - enable = 1 -> WAIT_START on the next edge.
  - On that transition: clear all sticky flags, CRC register and counters.
  - enable while busy is ignored.
- WAIT_START:
  - Samples dat_in every cycle; dat_in = 0 -> DATA. The start bit is not fed into the CRC.
  - Otherwise the counter increments. When timeout_reg != 0 and the counter reaches timeout_reg: set timeout_error, pulse block_done, go to IDLE.
  - If the start bit and the timeout occur in the same cycle, the start bit wins.
- DATA:
  - Each cycle, shift dat_in into the word register MSB-first and into the serial CRC16 (poly x^16+x^12+x^5+1, init 0).
  - After each 32nd bit, the following cycle presents data_out with write_fifo = 1 for exactly one cycle. Shifting continues uninterrupted; the word is double-buffered.
  - If fifo_full = 1 in the cycle the word completes: suppress write_fifo, drop the word, set overflow. Reception continues.
  - After BLOCK_BYTES*8 bits -> CRC.
- CRC:
  - Shift 16 bits MSB-first into the received-CRC register; the computed CRC is frozen.
  - After the 16th bit -> END.
- END:
  - Sample dat_in. A value of 0 sets end_error.
  - Compare the received and computed CRC; a mismatch sets crc_error.
  - Go to DONE.
- DONE: pulse block_done for one cycle, then go to IDLE. The last word's write_fifo has already been issued before DONE.
- Latency: start bit at cycle S -> first write_fifo at S+33 -> block_done at S + BLOCK_BYTES*8 + 18.
- Reset mid-operation: immediate return to IDLE and all outputs 0. No partial word is pushed.
- Sticky flags hold until the next accepted enable or reset.

Decomposition:
- Shared definitions include file holds:
  - state encodings: IDLE, WAIT_START, DATA, CRC, END, DONE;
  - CRC16 polynomial 16'h1021 and init value;
  - start/end bit level constants.
- One sub-module, sd_crc16_serial:
  - inputs: sd_clock, reset, clear, bit_valid, bit_in;
  - output: 16-bit crc.
  - The dat_phys transmit side reuses the same sub-module.

Test Plan:
- BLOCK_BYTES=8, timeout_reg=100, start bit after 10 idle cycles, data 32'hDEADBEEF then 32'h01234567, correct CRC, end bit 1 -> two write_fifo pulses with those values at S+33 and S+65; block_done at S+82; all error flags 0.
- Same stimulus with one received CRC bit flipped -> both words still pushed; crc_error = 1; end_error = 0; block_done pulses.
- Correct block with end bit 0 -> end_error = 1, crc_error = 0.
- timeout_reg=100, dat_in held high -> timeout_error = 1 and block_done 100 cycles after entering WAIT_START, no write_fifo. Repeat with timeout_reg=0 held for 1000 cycles -> stays in WAIT_START, busy = 1.
- fifo_full = 1 during the first word's completion, 0 for the second -> overflow = 1, only 32'h01234567 pushed, CRC still checked correct.
- reset asserted 20 bits into DATA -> all outputs 0 immediately; a subsequent enable plus a good block completes cleanly.
